// File: rtl/bcd_to_bin.sv
// bcd_to_bin: two-digit BCD to 7-bit binary converter.
// The conversion is a reverse double-dabble. The word {b1, b0, bin} is
// shifted right by one bit per clock. After each shift, any BCD digit that
// reads above 7 has 3 subtracted from it. Seven shifts empty the BCD digits
// into bin.
module bcd_to_bin (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic       ready,
  output logic       done_tick,
  output logic [6:0] bin
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] b1, b0, b1_nxt, b0_nxt;
  logic [6:0] bin_nxt;
  logic [2:0] n, n_nxt;
  logic [3:0] t0, t1;

  // The digits as they look after this cycle's right shift, before any
  // correction is applied.
  assign t0 = {b1[0], b0[3:1]};
  assign t1 = {1'b0, b1[3:1]};

  // State and datapath registers. An asynchronous reset abandons any
  // conversion that is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      b1    <= '0;
      b0    <= '0;
      bin   <= '0;
      n     <= '0;
    end else begin
      state <= state_nxt;
      b1    <= b1_nxt;
      b0    <= b0_nxt;
      bin   <= bin_nxt;
      n     <= n_nxt;
    end
  end

  // Next-state, datapath update and status decode.
  always_comb begin
    state_nxt = state;
    b1_nxt    = b1;
    b0_nxt    = b0;
    bin_nxt   = bin;
    n_nxt     = n;
    ready     = 1'b0;
    done_tick = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          b1_nxt    = bcd1;
          b0_nxt    = bcd0;
          bin_nxt   = '0;
          n_nxt     = 3'd7;
          state_nxt = OP;
        end
      end
      OP: begin
        bin_nxt = {b0[0], bin[6:1]};
        b0_nxt  = (t0 > 4'd7) ? t0 - 4'd3 : t0;
        b1_nxt  = (t1 > 4'd7) ? t1 - 4'd3 : t1;
        n_nxt   = n - 3'd1;
        // n==1 at the start of the cycle means this is the seventh shift.
        if (n == 3'd1) state_nxt = DONE;
      end
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed and exhaustive checks of the BCD-to-binary converter.
module tb_bcd_to_bin;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] bcd1, bcd0;
  logic       ready, done_tick;
  logic [6:0] bin;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d0;
    logic [6:0] exp_bin;
  } vec_t;

  vec_t vecs[6];

  bcd_to_bin dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd1      (bcd1),
    .bcd0      (bcd0),
    .ready     (ready),
    .done_tick (done_tick),
    .bin       (bin)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter, used to measure the spacing between done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Single conversion with start pulsed for one cycle. Call at a negedge
  // while the DUT is idle.
  task automatic run_conv(input logic [3:0] d1, input logic [3:0] d0,
                          input logic [6:0] exp_bin);
    int k;
    int ready_low;
    bcd1 = d1; bcd0 = d0; start = 1'b1;
    k = 0; ready_low = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (!ready) ready_low++;
      if (done_tick) break;
    end
    check($sformatf("latency %0d%0d", d1, d0), k, 8);
    check($sformatf("ready_low %0d%0d", d1, d0), ready_low, 8);
    check($sformatf("bin %0d%0d", d1, d0), bin, exp_bin);
    @(negedge clk);
    check($sformatf("ready_after %0d%0d", d1, d0), ready, 1);
    check($sformatf("done_after %0d%0d", d1, d0), done_tick, 0);
  endtask

  initial begin
    int k, dones, last_done, d1, d0;

    vecs[0] = '{4'd4, 4'd2, 7'd42};
    vecs[1] = '{4'd0, 4'd0, 7'd0};
    vecs[2] = '{4'd9, 4'd9, 7'd99};
    vecs[3] = '{4'd1, 4'd0, 7'd10};
    vecs[4] = '{4'd0, 4'd9, 7'd9};
    vecs[5] = '{4'd5, 4'd7, 7'd57};

    // Hold reset for 5 cycles, then release it.
    reset = 1'b0; start = 1'b0; bcd1 = 4'd0; bcd0 = 4'd0;
    repeat (5) @(negedge clk);
    check("rst ready", ready, 1);
    check("rst done", done_tick, 0);
    check("rst bin", bin, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle ready", ready, 1);
    check("idle done", done_tick, 0);
    check("idle bin", bin, 0);

    // Directed vectors.
    foreach (vecs[i]) run_conv(vecs[i].d1, vecs[i].d0, vecs[i].exp_bin);

    // bin keeps the previous result while idle.
    repeat (3) @(negedge clk);
    check("hold bin", bin, 57);

    // Exhaustive, back-to-back with start held high.
    start = 1'b1;
    last_done = 0;
    for (int i = 0; i < 100; i++) begin
      d1 = i / 10; d0 = i % 10;
      k = 0;
      do begin @(negedge clk); k++; end while (!ready && k < 20);
      bcd1 = 4'(d1); bcd0 = 4'(d0);
      k = 0;
      do begin @(negedge clk); k++; end while (!done_tick && k < 20);
      check($sformatf("exh done %0d", i), done_tick, 1);
      check($sformatf("exh bin %0d", i), bin, i);
      if (i > 0) check($sformatf("exh spacing %0d", i), cyc - last_done, 9);
      last_done = cyc;
    end
    start = 1'b0;
    @(negedge clk);
    check("exh end ready", ready, 1);

    // A start request and digit changes during OP are both ignored.
    bcd1 = 4'd3; bcd0 = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; bcd1 = 4'd8; bcd0 = 4'd1;
    repeat (3) @(negedge clk);
    start = 1'b0; bcd1 = 4'd2; bcd0 = 4'd5;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_tick) begin
        dones++;
        check("ign bin", bin, 36);
      end
    end
    check("ign dones", dones, 1);

    // Assert reset during the fourth OP cycle.
    bcd1 = 4'd7; bcd0 = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-rst ready", ready, 0);
    reset = 1'b0;
    #1;
    check("mid-rst bin", bin, 0);
    check("mid-rst ready", ready, 1);
    check("mid-rst done", done_tick, 0);
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_tick) dones++;
    end
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_tick) dones++;
    end
    check("mid-rst no done", dones, 0);
    run_conv(4'd7, 4'd7, 7'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound the run so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end before 200000");
    $fatal(1, "timeout");
  end

endmodule
